// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dm_arb_pkg;
  localparam int DEF_AW           = 8;
  localparam int DEF_DW           = 8;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {IDLE, RD, RSP} state_t;
  typedef enum logic {OWN_CORE, OWN_LDR} owner_t;
endpackage

// File: rtl/dm_starve_counter.sv
// Counts consecutive core grants taken while the loader waits; at_limit hands
// the next contested grant to the loader.
module dm_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_core_gnt,
  input  logic i_ldr_gnt,
  input  logic i_l_req,
  output logic o_at_limit
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_l_req || i_ldr_gnt) begin
      r_cnt <= '0;
    end else if (i_core_gnt && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_at_limit = (r_cnt == LIMIT);
endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the core and the loader port.
// Core has priority; the starvation counter forces periodic loader grants.
//
// state | meaning
// IDLE  | arbitrate; a granted write stays here, a granted read goes to RD
// RD    | memory read in progress, no grant; capture mem_rdata into rdata
// RSP   | pulse owner's rvalid and arbitrate again as in IDLE
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  input  logic          i_l_req,
  input  logic          i_l_we,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic          o_c_gnt,
  output logic          o_l_gnt,
  output logic          o_c_rvalid,
  output logic          o_l_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy
);
  state_t        r_state;
  state_t        w_state_nxt;
  owner_t        r_owner;
  logic [DW-1:0] r_rdata;
  logic          w_at_limit;
  logic          w_arb_ok;
  logic          w_c_win;
  logic          w_l_win;
  logic          w_win_we;
  logic          w_rd_grant;

  dm_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_core_gnt (w_c_win),
    .i_ldr_gnt  (w_l_win),
    .i_l_req    (i_l_req),
    .o_at_limit (w_at_limit)
  );

  // RSP arbitrates exactly like IDLE, so only RD blocks a grant.
  assign w_arb_ok   = (r_state != RD);
  assign w_c_win    = w_arb_ok & i_c_req & (~i_l_req | ~w_at_limit);
  assign w_l_win    = w_arb_ok & i_l_req & (~i_c_req | w_at_limit);
  assign w_win_we   = w_l_win ? i_l_we : i_c_we;
  assign w_rd_grant = (w_c_win | w_l_win) & ~w_win_we;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    unique case (r_state)
      IDLE, RSP: w_state_nxt = w_rd_grant ? RD : IDLE;
      RD:        w_state_nxt = RSP;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= OWN_CORE;
      r_rdata <= '0;
    end else begin
      if (w_rd_grant) begin
        r_owner <= w_l_win ? OWN_LDR : OWN_CORE;
      end
      if (r_state == RD) begin
        r_rdata <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    o_c_gnt     = w_c_win;
    o_l_gnt     = w_l_win;
    o_mem_en    = w_c_win | w_l_win;
    o_mem_we    = (w_c_win | w_l_win) & w_win_we;
    o_mem_addr  = w_l_win ? i_l_addr : i_c_addr;
    o_mem_wdata = w_l_win ? i_l_wdata : i_c_wdata;
    o_c_rvalid  = (r_state == RSP) && (r_owner == OWN_CORE);
    o_l_rvalid  = (r_state == RSP) && (r_owner == OWN_LDR);
    o_rdata     = r_rdata;
    o_busy      = (r_state != IDLE) | w_c_win | w_l_win;
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a grant/memory reference model pushes
// expected read responses, and a separate monitor checks them on rvalid.
module tb_dm_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0;
  logic          c_gnt, l_gnt, c_rvalid, l_rvalid, mem_en, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_c_gnt(c_gnt), .o_l_gnt(l_gnt), .o_c_rvalid(c_rvalid), .o_l_rvalid(l_rvalid),
    .o_rdata(rdata), .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return (i == 3) ? 8'h11 : 8'((i * 7) + 5);
  endfunction

  // Data memory: reloaded with a known pattern whenever reset is held.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {bit own_ldr; logic [7:0] data; int due;} rsp_t;
  rsp_t       q[$];
  logic [7:0] model_mem [256];
  int         streak = 0;
  int         rd_age = 10;
  logic       s_cg, s_lg, s_crv;
  logic [7:0] s_rdata;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    streak = 0;
    rd_age = 10;
    q.delete();
  endtask

  task automatic check_cycle();
    bit ec, el, lock, we;
    logic [7:0] a;
    rsp_t r;
    ec = 0; el = 0;
    lock = (rd_age == 1);
    if (!lock) begin
      if (c_req && l_req) begin
        if (streak >= SL) el = 1; else ec = 1;
      end else if (c_req) ec = 1;
      else if (l_req) el = 1;
    end
    we = el ? l_we : c_we;
    a  = el ? l_addr : c_addr;
    chk("gnt", {30'd0, c_gnt, l_gnt}, {30'd0, ec, el});
    chk("busy", busy, (rd_age == 1 || rd_age == 2 || ec || el));
    chk("mem_en", mem_en, ec | el);
    chk("mem_we", mem_we, (ec | el) & we);
    if (ec | el) begin
      chk("mem_addr", mem_addr, a);
      if (we) chk("mem_wdata", mem_wdata, el ? l_wdata : c_wdata);
    end
    s_cg = c_gnt; s_lg = l_gnt; s_crv = c_rvalid; s_rdata = rdata;
    if (ec | el) begin
      if (we) model_mem[a] = el ? l_wdata : c_wdata;
      else begin
        r.own_ldr = el; r.data = model_mem[a]; r.due = cyc + 2;
        q.push_back(r);
        rd_age = 0;
      end
    end
    if (rd_age < 10) rd_age++;
    if (el || !l_req) streak = 0;
    else if (ec) streak++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    if (s_cg) c_req = 1'b0;
    if (s_lg) l_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit exp = (q.size() > 0) && (q[0].due == cyc);
      if (c_rvalid || l_rvalid || exp) begin
        chk("rvalid", {30'd0, c_rvalid, l_rvalid},
            exp ? {30'd0, !q[0].own_ldr, q[0].own_ldr} : 32'd0);
        if (exp) begin
          chk("rdata", rdata, q[0].data);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();
    #1;
    chk("rst_cgnt", c_gnt, 0);   chk("rst_lgnt", l_gnt, 0);
    chk("rst_crv", c_rvalid, 0); chk("rst_lrv", l_rvalid, 0);
    chk("rst_rdata", rdata, 0);  chk("rst_en", mem_en, 0);
    chk("rst_we", mem_we, 0);    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Core write then read back through the two-cycle read path
    c_req = 1; c_we = 1; c_addr = 8'd31; c_wdata = 8'h5A; step();
    c_req = 1; c_we = 0; c_addr = 8'd31; step();
    idle(3);

    // Loader write arriving while a core read is in RD
    c_req = 1; c_we = 0; c_addr = 8'd3; step();
    l_req = 1; l_we = 1; l_addr = 8'd50; l_wdata = 8'd77; step();
    chk("rd_blocks_ldr", s_lg, 0);
    step();
    chk("rsp_lgnt", s_lg, 1);
    chk("rsp_crvalid", s_crv, 1);
    chk("rsp_rdata", s_rdata, 8'h11);
    idle(2);

    // Both hold writes: C,C,C,C,L repeating
    for (int i = 0; i < 15; i++) begin
      c_req = 1; c_we = 1; c_addr = 8'(i);       c_wdata = 8'(i + 1);
      l_req = 1; l_we = 1; l_addr = 8'(100 + i); l_wdata = 8'(i + 2);
      step();
      chk("starve_pat", {30'd0, s_cg, s_lg}, (i % 5 == 4) ? 32'd1 : 32'd2);
    end
    c_req = 0; l_req = 0;
    idle(2);

    // Reset asserted while a read sits in RD
    c_req = 1; c_we = 0; c_addr = 8'd7; step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstrd_crv", c_rvalid, 0); chk("rstrd_busy", busy, 0);
    chk("rstrd_rdata", rdata, 0);  chk("rstrd_en", mem_en, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    c_req = 1; c_we = 0; c_addr = 8'd3; step();
    chk("post_rst_gnt", s_cg, 1);
    idle(3);

    // Loader bulk preload 0..255, back to back
    n = 0;
    for (int i = 0; i < 256; i++) begin
      l_req = 1; l_we = 1; l_addr = 8'(i); l_wdata = 8'(i);
      step();
      if (s_lg) n++;
    end
    chk("preload_gnts", n, 256);
    l_req = 1; l_we = 0; l_addr = 8'd255; step();
    idle(3);

    // Randomized traffic on a small address window
    for (int i = 0; i < 400; i++) begin
      if (!c_req && $urandom_range(0, 1) == 1) begin
        c_req = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = 8'($urandom_range(0, 15)); c_wdata = 8'($urandom);
      end
      if (!l_req && $urandom_range(0, 2) != 0) begin
        l_req = 1; l_we = 1'($urandom_range(0, 1));
        l_addr = 8'($urandom_range(0, 15)); l_wdata = 8'($urandom);
      end
      step();
    end
    c_req = 0; l_req = 0;
    idle(4);
    chk("rsp_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Two-requester arbiter that shares the single-port 256x8 data memory between the processor datapath and a loader/debug port. The loader port is used for bulk preload and dump. The block sits between TopLevel's load/store path, the loader, and the data memory. Core accesses get priority, and a bounded starvation guard guarantees loader progress. Writes sustain one per cycle. Reads return data two cycles after the grant.

## Interface
- AW, 8, address width
- DW, 8, data width
- STARVE_LIMIT, 4, maximum consecutive core grants while the loader waits (>=1)

- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- c_req / l_req  in  1  core / loader request; held with its fields until the matching gnt
- c_we / l_we  in  1  1 = write, 0 = read
- c_addr / l_addr  in  AW  access address
- c_wdata / l_wdata  in  DW  write data
- c_gnt / l_gnt  out  1  access accepted this cycle (combinational)
- c_rvalid / l_rvalid  out  1  one-cycle pulse: rdata is valid for this requester
- rdata  out  DW  registered read data, shared by both requesters
- mem_en / mem_we  out  1  memory enable / write enable (combinational)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after a read is issued
- busy  out  1  a grant is active or a read is in flight

## Operation
- FSM has three states: IDLE, RD, RSP.
- **IDLE:** pick a winner and drive mem_* from it; pulse the winner's gnt.
  - A granted write stays in IDLE.
  - A granted read goes to RD and records the owner.
- **RD:** no grant. Capture mem_rdata into rdata. Go to RSP.
- **RSP:** pulse the owner's rvalid, then arbitrate exactly as in IDLE in the same cycle. Next state follows the IDLE rules.
- **Winner selection:**
  - Core only requesting: core wins.
  - Loader only requesting: loader wins.
  - Both requesting: core wins, unless starve_cnt == STARVE_LIMIT, in which case the loader wins.
- **starve_cnt** (width clog2(STARVE_LIMIT+1)):
  - Increments on a core grant while l_req=1.
  - Clears on a loader grant, or on any cycle with l_req=0.
  - Saturates at STARVE_LIMIT.
- rdata holds its value until the next read capture.
- When no grant is issued, mem_en=0 and mem_we=0. mem_addr and mem_wdata are don't-care.
- Addresses are passed through unchanged. There is no wrap or offset logic.

## Timing
- **Reset values:** state=IDLE, starve_cnt=0, rdata=0, both rvalids=0, both gnts=0, mem_en=0, mem_we=0, busy=0.
- Reset is honoured asynchronously, in any state.
- **Write:** gnt and mem_we in cycle N; memory written at the end of N. Throughput is one write per cycle.
- **Read:** gnt in cycle N → RD in N+1 → rvalid and rdata in N+2. A new grant is possible in N+2.
- Read throughput is one read every 2 cycles.
- A request that arrives while in RD waits at least one cycle.
- Simultaneous requests resolve per the winner rules; the losing requester sees gnt=0 and keeps holding.
- **Reset mid-read (RD or RSP):** the read is dropped. No rvalid is issued, and rdata=0.
- **Reset mid-write:** the memory-side result is undefined. The arbiter still returns to IDLE.
- busy = (state != IDLE) | c_gnt | l_gnt.

## Structure
- Package dm_arb_pkg holds:
  - enum state_t {IDLE, RD, RSP};
  - enum owner_t {OWN_CORE, OWN_LDR};
  - default AW/DW localparams.
- Sub-module dm_starve_counter holds the saturating counter. It takes inputs core_gnt, ldr_gnt, l_req and outputs at_limit.
- The top holds the FSM, the winner mux and the rdata register.

## Test plan
- Core write addr 31 data 8'h5A, then core read addr 31 → c_gnt and mem_we=1 in cycle N; read c_gnt at M; c_rvalid at M+2 with rdata=8'h5A.
- Both requesters hold writes continuously, STARVE_LIMIT=4 → grant pattern C,C,C,C,L repeating; starve_cnt returns to 0 after each L.
- Core read addr 3 (mem=8'h11) at N, loader write requested from N+1 → l_gnt=0 at N+1; at N+2, l_gnt=1 together with c_rvalid=1 and rdata=8'h11.
- Reset driven low during RD → no c_rvalid; all outputs 0 immediately; after release, first core request is granted from IDLE.
- Loader alone writes addr 0..255 (data = addr) back-to-back → 256 l_gnt pulses in 256 cycles; then loader read of addr 255 → rdata=8'hFF.
